fetch_exec_sequencer: RTL and testbench
=======================================

// Module: fetch_exec_sequencer
// PURPOSE
// Multi-cycle control sequencer for the teaching CPU: extends the IDLE/FETCH/EXEC run/halt
// scheme with memory handshakes, decode, load/store and writeback. Owns PC and IR, issues
// fetch and data memory requests, and drives ALU/register-file control to the datapath.
// Sits between the external run/halt controls, the memory port and the datapath.
// PARAMETERS
// AW  8   memory address / PC width; jump and load/store address = ir[AW-1:0] (AW <= 12)
// IW  16  instruction width; opcode = ir[IW-1:IW-4]
// PORTS
// clk        in   1   single clock, rising edge
// reset      in   1   asynchronous, active-high reset
// run        in   1   start fetching from the current PC (level, sampled in IDLE)
// halt       in   1   stop after the current instruction (level, sampled every cycle)
// mem_req    out  1   memory request, held until mem_ack
// mem_we     out  1   1 = store, 0 = read; valid while mem_req is high
// mem_addr   out  AW  PC in FETCH, ir[AW-1:0] in MEM
// mem_ack    in   1   single-cycle completion strobe; ignored when mem_req = 0
// mem_rdata  in   IW  instruction word, valid with mem_ack in FETCH
// alu_zero   in   1   datapath zero flag, valid in EXEC
// ir         out  IW  instruction register
// pc         out  AW  program counter
// alu_op     out  2   00 pass, 01 add, 10 sub; forced to 00 outside EXEC
// reg_we     out  1   register-file write strobe, one cycle in WB
// cs         out  3   current state encoding
// err        out  1   sticky illegal-opcode flag, cleared by reset or by run in IDLE
// BEHAVIOUR
// Reset: cs=IDLE; pc, ir, alu_op = 0; mem_req, mem_we, reg_we, err = 0; halt_pend=0.
// Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 LD, 4 ST, 5 JMP, 6 BEQZ, F HLT; all others illegal.
// States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
// - IDLE: if run, go to FETCH and clear err. halt is ignored in IDLE; run wins.
// - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: ir<=mem_rdata, pc<=pc+1 (wraps
//   mod 2^AW), go to DECODE. Without ack, stay in FETCH indefinitely.
// - DECODE: 1 cycle. On illegal opcode: err<=1 and go to IDLE; no other outputs change.
// - EXEC: 1 cycle. alu_op is 01 for ADD, 10 for SUB, else 00.
//   JMP: pc<=ir[AW-1:0]. BEQZ: if alu_zero, pc<=ir[AW-1:0].
//   LD/ST go to MEM; ADD/SUB go to WB; HLT goes to IDLE; NOP/JMP/BEQZ go to the end-step.
// - MEM: mem_req=1, mem_we=(op==ST), mem_addr=ir[AW-1:0]. On mem_ack: LD goes to WB,
//   ST goes to the end-step.
// - WB: reg_we=1 for exactly 1 cycle, then the end-step.
// - End-step: if halt_pend or halt is high, go to IDLE; otherwise go to FETCH.
// halt_pend: set by halt in any non-IDLE state; cleared on entry to IDLE. A halt pulse is
//   never lost mid-instruction.
// mem_req/mem_we/mem_addr are combinational from cs and ir/pc and are glitch-free.
//   mem_req drops in the cycle after ack.
// Latency: NOP = 3 cycles with a 0-wait ack (FETCH, DECODE, EXEC); ADD = 4; LD = 5.
// Reset mid-operation (including during FETCH/MEM) returns to IDLE asynchronously and
//   drops mem_req at once.
// STRUCTURE
// Shared package fe_seq_pkg: state localparams S_IDLE..S_WB, opcode localparams OP_*,
//   ALU_* codes.
// The sequencer is one module with one always_ff for cs/pc/ir/err/halt_pend and one
//   combinational block for outputs.
// No sub-module, except an optional fe_decode (opcode -> is_alu/is_mem/is_br/illegal)
//   if reuse is needed.
// TESTING
// 1. Apply reset, then release it with run=0 -> cs=0, pc=0, mem_req=0 held for 10 cycles.
// 2. Pulse run; memory returns 0x1000 (ADD) with 0-wait ack ->
//    cs sequence 1,2,3,5,1; alu_op=01 in EXEC; reg_we for 1 cycle; pc=1.
// 3. LD 0x3042 with 2-wait ack in MEM -> mem_addr=0x42, mem_we=0 for 3 cycles, then WB; ST 0x4010 -> mem_we=1.
// 4. JMP 0x50FE -> pc=0xFE, next fetch at 0xFE, then 0xFF, then wraps to 0x00.
//    BEQZ with alu_zero=0 -> pc unchanged.
// 5. 1-cycle halt pulse during a FETCH wait -> the instruction completes, then IDLE.
//    Opcode 0x7 -> err=1, IDLE; a new run clears err.
// 6. Assert reset during MEM with mem_req=1 -> mem_req=0 and cs=0 in the same cycle;
//    a late mem_ack is ignored.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fe_seq_pkg
//  Description : Shared state, opcode and ALU encodings for the
//                fetch/decode/execute sequencer of the teaching CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package fe_seq_pkg;

    // Sequencer states; the numeric value is exported on the cs port
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Opcodes (ir[IW-1:IW-4])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_BEQZ = 4'h6;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // ALU control codes
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Opcodes 7..E have no meaning and raise err in DECODE
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_BEQZ) || (op == OP_HLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_exec_sequencer
//  Description : Multi-cycle control sequencer. Owns PC and IR, issues fetch
//                and load/store requests, drives ALU and register-file
//                control, and honours run/halt at instruction boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_exec_sequencer
    import fe_seq_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          halt,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [IW-1:0] mem_rdata,
    input  logic          alu_zero,
    output logic [IW-1:0] ir,
    output logic [AW-1:0] pc,
    output logic [1:0]    alu_op,
    output logic          reg_we,
    output logic [2:0]    cs,
    output logic          err
);

    state_t          r_cs,        w_cs_nxt;
    logic [AW-1:0]   r_pc,        w_pc_nxt;
    logic [IW-1:0]   r_ir,        w_ir_nxt;
    logic            r_err,       w_err_nxt;
    logic            r_halt_pend, w_halt_pend_nxt;

    logic [3:0]      w_op;
    logic [AW-1:0]   w_tgt;
    state_t          w_end_state;

    assign w_op  = r_ir[IW-1:IW-4];
    assign w_tgt = r_ir[AW-1:0];

    // Instruction boundary: stop if a halt was seen during this instruction
    assign w_end_state = (r_halt_pend || halt) ? S_IDLE : S_FETCH;

    // State register; reset is asynchronous so a stuck request drops at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cs        <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_err       <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_cs        <= w_cs_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_err       <= w_err_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    // Next-state and output decode; all outputs derive from registered state only
    always_comb begin
        w_cs_nxt        = r_cs;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_err_nxt       = r_err;
        w_halt_pend_nxt = r_halt_pend || (halt && (r_cs != S_IDLE));
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        alu_op          = ALU_PASS;
        reg_we          = 1'b0;

        case (r_cs)
            S_IDLE: begin
                if (run) begin
                    w_cs_nxt  = S_FETCH;
                    w_err_nxt = 1'b0;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) begin
                    w_ir_nxt = mem_rdata;
                    w_pc_nxt = r_pc + AW'(1);
                    w_cs_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!op_is_legal(w_op)) begin
                    w_err_nxt = 1'b1;
                    w_cs_nxt  = S_IDLE;
                end else begin
                    w_cs_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_op)
                    OP_ADD:  begin alu_op = ALU_ADD; w_cs_nxt = S_WB; end
                    OP_SUB:  begin alu_op = ALU_SUB; w_cs_nxt = S_WB; end
                    OP_LD,
                    OP_ST:   w_cs_nxt = S_MEM;
                    OP_HLT:  w_cs_nxt = S_IDLE;
                    OP_JMP:  begin w_pc_nxt = w_tgt; w_cs_nxt = w_end_state; end
                    OP_BEQZ: begin
                        if (alu_zero) w_pc_nxt = w_tgt;
                        w_cs_nxt = w_end_state;
                    end
                    default: w_cs_nxt = w_end_state;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (w_op == OP_ST);
                mem_addr = w_tgt;
                if (mem_ack) w_cs_nxt = (w_op == OP_LD) ? S_WB : w_end_state;
            end
            S_WB: begin
                reg_we   = 1'b1;
                w_cs_nxt = w_end_state;
            end
            default: w_cs_nxt = S_IDLE;
        endcase

        // A pending halt is consumed when the sequencer parks in IDLE
        if (w_cs_nxt == S_IDLE) w_halt_pend_nxt = 1'b0;
    end

    assign ir  = r_ir;
    assign pc  = r_pc;
    assign cs  = r_cs;
    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_exec_sequencer
//  Description : Directed self-checking bench for fetch_exec_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_exec_sequencer;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          halt;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          alu_zero;
    logic [IW-1:0] ir;
    logic [AW-1:0] pc;
    logic [1:0]    alu_op;
    logic          reg_we;
    logic [2:0]    cs;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_exec_sequencer #(.AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halt      (halt),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .alu_zero  (alu_zero),
        .ir        (ir),
        .pc        (pc),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .cs        (cs),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch word with a 0-wait ack and take the edge into DECODE
    task automatic feed(input logic [IW-1:0] word);
        mem_rdata = word;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; halt = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; alu_zero = 1'b0;
        step(); step();
        reset = 1'b0;

        // 1. idle after reset
        chk("rst_ir", ir, 0);
        chk("rst_err", err, 0);
        chk("rst_alu", alu_op, 0);
        chk("rst_we", {mem_we, reg_we}, 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_cs", cs, 0);
            chk("idle_pc", pc, 0);
            chk("idle_req", mem_req, 0);
            step();
        end

        // 2. ADD with 0-wait fetch
        run = 1'b1;
        step();
        run = 1'b0;
        chk("add_cs_f", cs, 1);
        chk("add_req", mem_req, 1);
        chk("add_addr", mem_addr, 8'h00);
        chk("add_we", mem_we, 0);
        feed(16'h1000);
        chk("add_cs_d", cs, 2);
        chk("add_ir", ir, 16'h1000);
        chk("add_pc", pc, 1);
        chk("add_req_drop", mem_req, 0);
        chk("add_alu_d", alu_op, 0);
        step();
        chk("add_cs_e", cs, 3);
        chk("add_alu_e", alu_op, 2'b01);
        chk("add_rwe_e", reg_we, 0);
        step();
        chk("add_cs_wb", cs, 5);
        chk("add_rwe_wb", reg_we, 1);
        chk("add_alu_wb", alu_op, 0);
        step();
        chk("add_cs_f2", cs, 1);
        chk("add_rwe_off", reg_we, 0);
        chk("add_addr2", mem_addr, 8'h01);

        // 3. LD with 2-wait ack, then ST
        feed(16'h3042);
        chk("ld_pc", pc, 2);
        step();
        chk("ld_cs_e", cs, 3);
        chk("ld_alu_e", alu_op, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ld_cs_mem", cs, 4);
            chk("ld_req", mem_req, 1);
            chk("ld_addr", mem_addr, 8'h42);
            chk("ld_we", mem_we, 0);
            if (i == 2) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        chk("ld_cs_wb", cs, 5);
        chk("ld_req_drop", mem_req, 0);
        chk("ld_rwe", reg_we, 1);
        step();
        chk("ld_cs_f", cs, 1);
        feed(16'h4010);
        step();
        step();
        chk("st_cs_mem", cs, 4);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 8'h10);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_cs_f", cs, 1);
        chk("st_rwe", reg_we, 0);
        chk("st_addr_f", mem_addr, 8'h03);

        // 4. JMP to 0xFE and sequential wrap, then BEQZ not-taken / taken
        feed(16'h50FE);
        step();
        step();
        chk("jmp_cs_f", cs, 1);
        chk("jmp_pc", pc, 8'hFE);
        chk("jmp_addr", mem_addr, 8'hFE);
        feed(16'h0000);
        chk("nop_pc_ff", pc, 8'hFF);
        step();
        step();
        chk("nop_addr_ff", mem_addr, 8'hFF);
        feed(16'h0000);
        chk("wrap_pc", pc, 8'h00);
        step();
        step();
        chk("wrap_addr", mem_addr, 8'h00);
        feed(16'h60AA);
        step();
        alu_zero = 1'b0;
        step();
        chk("beqz_nt_pc", pc, 8'h01);
        chk("beqz_nt_cs", cs, 1);
        feed(16'h6033);
        alu_zero = 1'b1;
        step();
        step();
        alu_zero = 1'b0;
        chk("beqz_t_pc", pc, 8'h33);

        // 5. halt pulse while fetch is waiting
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_stay_f", cs, 1);
        step();
        step();
        feed(16'h1000);
        step();
        step();
        chk("halt_cs_wb", cs, 5);
        step();
        chk("halt_cs_idle", cs, 0);
        chk("halt_req", mem_req, 0);
        chk("halt_pc", pc, 8'h34);
        step();
        chk("halt_idle_hold", cs, 0);

        // illegal opcode, then run clears err; halt_pend must not linger
        run = 1'b1;
        step();
        run = 1'b0;
        feed(16'h7000);
        step();
        chk("ill_cs", cs, 0);
        chk("ill_err", err, 1);
        chk("ill_alu", alu_op, 0);
        step();
        chk("ill_err_sticky", err, 1);
        run = 1'b1;
        step();
        run = 1'b0;
        chk("run_clr_err", err, 0);
        chk("run_cs", cs, 1);
        feed(16'h0000);
        step();
        step();
        chk("nop_no_halt", cs, 1);
        feed(16'hF000);
        step();
        step();
        chk("hlt_cs", cs, 0);

        // 6. asynchronous reset while MEM holds a request
        run = 1'b1;
        step();
        run = 1'b0;
        feed(16'h3042);
        step();
        step();
        chk("rstm_cs_mem", cs, 4);
        chk("rstm_req_pre", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstm_req", mem_req, 0);
        chk("rstm_cs", cs, 0);
        chk("rstm_pc", pc, 0);
        mem_ack = 1'b1;
        step();
        reset = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("late_ack_cs", cs, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_ir", ir, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
